xge_pkt_store_fwd: RTL and testbench

XGE_PKT_STORE_FWD -- requirements
Module: xge_pkt_store_fwd

---
 rtl/xge_pkt_store_fwd.sv | 207 ++++++++++++++++++++
 tb/tb_xge_pkt_store_fwd.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xge_pkt_store_fwd.sv
// Store-and-forward packet FIFO for a 10G packet interface.
// RX words are written speculatively and only become visible to TX once the
// packet's eop word is committed; errored or oversized packets are rewound.
module xge_pkt_store_fwd #(
  parameter int DATA_W   = 64,
  parameter int MOD_W    = $clog2(DATA_W/8),
  parameter int DEPTH    = 256,
  parameter bit DROP_ERR = 1'b1
) (
  input  logic              clk_156m25,
  input  logic              reset_156m25,
  input  logic              pkt_rx_avail,
  output logic              pkt_rx_ren,
  input  logic              pkt_rx_val,
  input  logic              pkt_rx_sop,
  input  logic              pkt_rx_eop,
  input  logic              pkt_rx_err,
  input  logic [MOD_W-1:0]  pkt_rx_mod,
  input  logic [DATA_W-1:0] pkt_rx_data,
  input  logic              pkt_tx_full,
  output logic              pkt_tx_val,
  output logic              pkt_tx_sop,
  output logic              pkt_tx_eop,
  output logic [MOD_W-1:0]  pkt_tx_mod,
  output logic [DATA_W-1:0] pkt_tx_data,
  output logic [15:0]       stat_fwd,
  output logic [15:0]       stat_drop_err,
  output logic [15:0]       stat_drop_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 1 + MOD_W + DATA_W;
  localparam logic [AW:0] DEPTH_WORDS = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE     = (AW+1)'(1);

  typedef enum logic [1:0] {RX_IDLE, RX_READ, RX_DISCARD} rx_state_e;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [EW-1:0] fifo_mem [DEPTH];

  rx_state_e rx_state_q, rx_state_d;
  tx_state_e tx_state_q, tx_state_d;
  logic rx_ren_q, rx_ren_d;
  logic [AW:0] wr_spec_q, wr_spec_d, wr_cmt_q, wr_cmt_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d, pkt_cnt_q, pkt_cnt_d;
  logic tx_first_q, tx_first_d;
  logic tx_val_q, tx_val_d, tx_sop_q, tx_sop_d, tx_eop_q, tx_eop_d;
  logic [MOD_W-1:0]  tx_mod_q, tx_mod_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [15:0] stat_fwd_q, stat_fwd_d, stat_err_q, stat_err_d, stat_ovf_q, stat_ovf_d;

  logic [AW:0] used;
  logic fifo_full, mem_we, commit, drop_err, drop_ovf, tx_launch, tx_done;
  logic [EW-1:0] rd_entry;
  logic rd_eop;
  logic [MOD_W-1:0]  rd_mod;
  logic [DATA_W-1:0] rd_data;
  logic rx_sop_unused;

  // A mid-packet sop never restarts a packet, so sop is not needed on RX.
  assign rx_sop_unused = pkt_rx_sop;
  // Occupancy counts speculative words so an in-flight packet cannot overrun TX.
  assign used      = wr_spec_q - rd_ptr_q;
  assign fifo_full = (used == DEPTH_WORDS);
  assign rd_entry  = fifo_mem[rd_ptr_q[AW-1:0]];
  assign rd_eop    = rd_entry[EW-1];
  assign rd_mod    = rd_entry[DATA_W +: MOD_W];
  assign rd_data   = rd_entry[DATA_W-1:0];

  // RX FSM: speculative write, commit on good eop, rewind on error or overflow.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_ren_d   = rx_ren_q;
    wr_spec_d  = wr_spec_q;
    wr_cmt_d   = wr_cmt_q;
    mem_we     = 1'b0;
    commit     = 1'b0;
    drop_err   = 1'b0;
    drop_ovf   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (pkt_rx_avail && !fifo_full) begin
          rx_state_d = RX_READ;
          rx_ren_d   = 1'b1;
        end
      end
      RX_READ: begin
        if (pkt_rx_val) begin
          if (fifo_full) begin
            wr_spec_d = wr_cmt_q;
            drop_ovf  = 1'b1;
            if (pkt_rx_eop) begin
              rx_state_d = RX_IDLE;
              rx_ren_d   = 1'b0;
            end else begin
              rx_state_d = RX_DISCARD;
            end
          end else begin
            mem_we    = 1'b1;
            wr_spec_d = wr_spec_q + PTR_ONE;
            if (pkt_rx_eop) begin
              rx_state_d = RX_IDLE;
              rx_ren_d   = 1'b0;
              if (pkt_rx_err && DROP_ERR) begin
                wr_spec_d = wr_cmt_q;
                drop_err  = 1'b1;
              end else begin
                wr_cmt_d = wr_spec_q + PTR_ONE;
                commit   = 1'b1;
              end
            end
          end
        end
      end
      default: begin
        if (pkt_rx_val && pkt_rx_eop) begin
          rx_state_d = RX_IDLE;
          rx_ren_d   = 1'b0;
        end
      end
    endcase
  end

  // TX FSM: launch one committed word per cycle whenever the sink was not full.
  always_comb begin
    if (tx_state_q == TX_IDLE) tx_launch = (pkt_cnt_q != '0) && !pkt_tx_full;
    else                       tx_launch = !pkt_tx_full;
    tx_done = tx_launch && rd_eop;

    pkt_cnt_d = pkt_cnt_q;
    if (commit && !tx_done)      pkt_cnt_d = pkt_cnt_q + PTR_ONE;
    else if (!commit && tx_done) pkt_cnt_d = pkt_cnt_q - PTR_ONE;

    tx_state_d = tx_state_q;
    if (tx_done)        tx_state_d = (pkt_cnt_d != '0) ? TX_SEND : TX_IDLE;
    else if (tx_launch) tx_state_d = TX_SEND;

    rd_ptr_d   = tx_launch ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    tx_first_d = tx_launch ? rd_eop : tx_first_q;
    tx_val_d   = tx_launch;
    tx_sop_d   = tx_launch && tx_first_q;
    tx_eop_d   = tx_done;
    tx_mod_d   = tx_done ? rd_mod : '0;
    tx_data_d  = tx_launch ? rd_data : '0;

    stat_fwd_d = tx_done  ? sat_inc(stat_fwd_q) : stat_fwd_q;
    stat_err_d = drop_err ? sat_inc(stat_err_q) : stat_err_q;
    stat_ovf_d = drop_ovf ? sat_inc(stat_ovf_q) : stat_ovf_q;
  end

  // Packet storage; entries are {eop, mod, data}, sop is rebuilt on TX.
  always_ff @(posedge clk_156m25) begin
    if (mem_we) fifo_mem[wr_spec_q[AW-1:0]] <= {pkt_rx_eop, pkt_rx_mod, pkt_rx_data};
  end

  // State, pointer, output and statistics registers.
  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      rx_state_q <= RX_IDLE;
      tx_state_q <= TX_IDLE;
      rx_ren_q   <= 1'b0;
      wr_spec_q  <= '0;
      wr_cmt_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      tx_first_q <= 1'b1;
      tx_val_q   <= 1'b0;
      tx_sop_q   <= 1'b0;
      tx_eop_q   <= 1'b0;
      tx_mod_q   <= '0;
      tx_data_q  <= '0;
      stat_fwd_q <= '0;
      stat_err_q <= '0;
      stat_ovf_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
      rx_ren_q   <= rx_ren_d;
      wr_spec_q  <= wr_spec_d;
      wr_cmt_q   <= wr_cmt_d;
      rd_ptr_q   <= rd_ptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      tx_first_q <= tx_first_d;
      tx_val_q   <= tx_val_d;
      tx_sop_q   <= tx_sop_d;
      tx_eop_q   <= tx_eop_d;
      tx_mod_q   <= tx_mod_d;
      tx_data_q  <= tx_data_d;
      stat_fwd_q <= stat_fwd_d;
      stat_err_q <= stat_err_d;
      stat_ovf_q <= stat_ovf_d;
    end
  end

  assign pkt_rx_ren    = rx_ren_q;
  assign pkt_tx_val    = tx_val_q;
  assign pkt_tx_sop    = tx_sop_q;
  assign pkt_tx_eop    = tx_eop_q;
  assign pkt_tx_mod    = tx_mod_q;
  assign pkt_tx_data   = tx_data_q;
  assign stat_fwd      = stat_fwd_q;
  assign stat_drop_err = stat_err_q;
  assign stat_drop_ovf = stat_ovf_q;
endmodule

// File: tb/tb_xge_pkt_store_fwd.sv
// Bench for xge_pkt_store_fwd: a packet source feeds randomized packets, and a
// packet-level model (expected word queue plus fate counters) predicts output.
module tb_xge_pkt_store_fwd;
  localparam int DATA_W = 64;
  localparam int MOD_W  = 3;
  localparam int DEPTH  = 16;

  logic              clk          = 1'b0;
  logic              rst          = 1'b1;
  logic              pkt_rx_avail = 1'b0;
  logic              pkt_rx_val   = 1'b0;
  logic              pkt_rx_sop   = 1'b0;
  logic              pkt_rx_eop   = 1'b0;
  logic              pkt_rx_err   = 1'b0;
  logic [MOD_W-1:0]  pkt_rx_mod   = '0;
  logic [DATA_W-1:0] pkt_rx_data  = '0;
  logic              pkt_tx_full  = 1'b0;
  logic              pkt_rx_ren;
  logic              pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
  logic [MOD_W-1:0]  pkt_tx_mod;
  logic [DATA_W-1:0] pkt_tx_data;
  logic [15:0]       stat_fwd, stat_drop_err, stat_drop_ovf;

  xge_pkt_store_fwd #(.DATA_W(DATA_W), .MOD_W(MOD_W), .DEPTH(DEPTH), .DROP_ERR(1'b1)) dut (
    .clk_156m25(clk), .reset_156m25(rst),
    .pkt_rx_avail(pkt_rx_avail), .pkt_rx_ren(pkt_rx_ren), .pkt_rx_val(pkt_rx_val),
    .pkt_rx_sop(pkt_rx_sop), .pkt_rx_eop(pkt_rx_eop), .pkt_rx_err(pkt_rx_err),
    .pkt_rx_mod(pkt_rx_mod), .pkt_rx_data(pkt_rx_data),
    .pkt_tx_full(pkt_tx_full), .pkt_tx_val(pkt_tx_val), .pkt_tx_sop(pkt_tx_sop),
    .pkt_tx_eop(pkt_tx_eop), .pkt_tx_mod(pkt_tx_mod), .pkt_tx_data(pkt_tx_data),
    .stat_fwd(stat_fwd), .stat_drop_err(stat_drop_err), .stat_drop_ovf(stat_drop_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [MOD_W-1:0]  mod;
    logic head, sop, eop, err, good;
    int   len;
  } src_word_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [MOD_W-1:0]  mod;
    logic sop, eop;
  } exp_word_t;

  src_word_t src_q[$];
  exp_word_t exp_q[$];

  int checks = 0, errors = 0;
  int exp_fwd = 0, exp_err = 0, exp_ovf = 0;
  int cyc = 0, words_seen = 0, good_issued = 0, rx_pops = 0;
  int commit_cyc = 0, sop_cyc = 0;
  int val_pct = 100, full_mode = 0, pulse_at = -1, pulse_cnt = 0;
  int gap_cnt = 0;
  bit gate_en = 1'b1, gap_en = 1'b0, gap_seen = 1'b0, in_pkt = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // fate: 0 forwarded, 1 overflow drop, 2 lost to reset (no trace anywhere)
  task automatic add_pkt(input int len, input bit err, input bit noise, input int fate);
    int noise_idx;
    src_word_t w;
    noise_idx = (noise && len > 2) ? int'($urandom_range(len-2, 1)) : -1;
    for (int i = 0; i < len; i++) begin
      w.data = {$urandom, $urandom};
      w.mod  = MOD_W'($urandom_range(7, 0));
      w.head = (i == 0);
      w.sop  = (i == 0) || (i == noise_idx);
      w.eop  = (i == len-1);
      w.err  = err && (i == len-1);
      w.good = !err && (fate == 0);
      w.len  = len;
      src_q.push_back(w);
      if (w.good) exp_q.push_back('{w.data, w.eop ? w.mod : '0, i == 0, w.eop});
    end
    if (err)            exp_err++;
    else if (fate == 1) exp_ovf++;
    else if (fate == 0) exp_fwd++;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor/scoreboard first, then source and sink stimulus, once per negedge.
  always @(negedge clk) begin : drive_mon
    src_word_t w;
    exp_word_t e;
    if (!rst) begin
      if (pkt_tx_val) begin
        if (exp_q.size() == 0) begin
          chk("tx_unexpected_val", 64'(pkt_tx_val), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", pkt_tx_data, e.data);
          chk("tx_sop", 64'(pkt_tx_sop), 64'(e.sop));
          chk("tx_eop", 64'(pkt_tx_eop), 64'(e.eop));
          chk("tx_mod", 64'(pkt_tx_mod), 64'(e.mod));
          words_seen++;
          if (pkt_tx_sop) sop_cyc = cyc;
          if (words_seen == pulse_at) pulse_cnt = 3;
        end
      end
      if (gap_en) begin
        if (pkt_tx_val) gap_seen = 1'b1;
        else if (gap_seen && exp_q.size() != 0) gap_cnt++;
      end else begin
        gap_seen = 1'b0;
      end
    end
    pkt_rx_val  = 1'b0;
    pkt_rx_data = {$urandom, $urandom};
    pkt_rx_sop  = 1'($urandom_range(1, 0));
    pkt_rx_eop  = 1'($urandom_range(1, 0));
    pkt_rx_err  = 1'($urandom_range(1, 0));
    pkt_rx_mod  = MOD_W'($urandom_range(7, 0));
    if (rst) begin
      src_q.delete();
      in_pkt       = 1'b0;
      good_issued  = 0;
      words_seen   = 0;
      pkt_rx_avail = 1'b0;
    end else begin
      if (pkt_rx_ren && src_q.size() != 0 && int'($urandom_range(99, 0)) < val_pct) begin
        w = src_q.pop_front();
        pkt_rx_val  = 1'b1;
        pkt_rx_data = w.data;
        pkt_rx_sop  = w.sop;
        pkt_rx_eop  = w.eop;
        pkt_rx_err  = w.err;
        pkt_rx_mod  = w.mod;
        in_pkt = !w.eop;
        if (w.head && w.good) good_issued += w.len;
        if (w.eop) commit_cyc = cyc;
        rx_pops++;
      end
      if (src_q.size() == 0)      pkt_rx_avail = 1'b0;
      else if (in_pkt || !gate_en) pkt_rx_avail = 1'b1;
      else pkt_rx_avail = (good_issued - words_seen + src_q[0].len) <= DEPTH;
    end
    if (pulse_cnt > 0) begin
      pkt_tx_full = 1'b1;
      pulse_cnt--;
    end else begin
      case (full_mode)
        0:       pkt_tx_full = 1'b0;
        1:       pkt_tx_full = 1'b1;
        default: pkt_tx_full = ($urandom_range(3, 0) == 0);
      endcase
    end
  end

  task automatic wait_drain(input string tag, input int max_cyc);
    int n = 0;
    while ((src_q.size() != 0 || in_pkt || exp_q.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n < max_cyc), 64'(1));
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_loaded(input string tag, input int max_cyc);
    int n = 0;
    while ((src_q.size() != 0 || in_pkt) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n < max_cyc), 64'(1));
    repeat (4) @(negedge clk);
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_stat_fwd"}, 64'(stat_fwd), 64'(exp_fwd));
    chk({tag, "_stat_drop_err"}, 64'(stat_drop_err), 64'(exp_err));
    chk({tag, "_stat_drop_ovf"}, 64'(stat_drop_ovf), 64'(exp_ovf));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_ren"}, 64'(pkt_rx_ren), 64'(0));
    chk({tag, "_tx_val"}, 64'(pkt_tx_val), 64'(0));
    chk({tag, "_tx_sop"}, 64'(pkt_tx_sop), 64'(0));
    chk({tag, "_tx_eop"}, 64'(pkt_tx_eop), 64'(0));
    chk({tag, "_tx_mod"}, 64'(pkt_tx_mod), 64'(0));
    chk({tag, "_tx_data"}, pkt_tx_data, 64'(0));
    check_stats(tag);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single 8-word packet with an idle sink: latency commit -> sop is 2.
    add_pkt(8, 1'b0, 1'b0, 0);
    wait_drain("single_drain", 200);
    chk("sop_latency", 64'(sop_cyc - commit_cyc), 64'(2));
    check_stats("single");

    // Errored packet dropped, then a good 4-word one, then a 16-word packet
    // that only fits if the errored words were fully released.
    add_pkt(6, 1'b1, 1'b0, 0);
    add_pkt(4, 1'b0, 1'b0, 0);
    wait_drain("err_drain", 300);
    add_pkt(DEPTH, 1'b0, 1'b0, 0);
    wait_drain("fill_drain", 300);
    check_stats("err");

    // 20-word packet overflows the 16-word FIFO; the next 3-word one survives.
    gate_en = 1'b0;
    add_pkt(20, 1'b0, 1'b0, 1);
    add_pkt(3, 1'b0, 1'b0, 0);
    wait_drain("ovf_drain", 300);
    gate_en = 1'b1;
    chk("ovf_rx_ren_idle", 64'(pkt_rx_ren), 64'(0));
    check_stats("ovf");

    // Three 5-word packets queued behind a full sink, then a 3-cycle full
    // pulse in the middle of packet 2.
    full_mode = 1;
    for (int i = 0; i < 3; i++) add_pkt(5, 1'b0, 1'b0, 0);
    wait_loaded("b2b_load", 300);
    gap_cnt  = 0;
    pulse_at = words_seen + 7;
    gap_en   = 1'b1;
    full_mode = 0;
    wait_drain("b2b_drain", 300);
    gap_en   = 1'b0;
    pulse_at = -1;
    chk("b2b_gap_cycles", 64'(gap_cnt), 64'(3));
    check_stats("b2b");

    // Randomized traffic: lengths, errors, stray mid-packet sop, val gaps, backpressure.
    val_pct   = 75;
    full_mode = 2;
    for (int i = 0; i < 30; i++)
      add_pkt(int'($urandom_range(8, 1)), ($urandom_range(4, 0) == 0), ($urandom_range(2, 0) == 0), 0);
    wait_drain("rand_drain", 6000);
    val_pct   = 100;
    full_mode = 0;
    check_stats("rand");

    // Reset arrives while word 3 of a 10-word packet is on the bus.
    n = rx_pops + 3;
    add_pkt(10, 1'b0, 1'b0, 2);
    begin
      int k = 0;
      while (rx_pops < n && k < 200) begin
        @(negedge clk);
        k++;
      end
      chk("midrst_reach_word3", 64'(k < 200), 64'(1));
    end
    rst = 1'b1;
    @(negedge clk);
    exp_fwd = 0;
    exp_err = 0;
    exp_ovf = 0;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check_stats("midrst_after");

    // Pointer wrap: 40 packets of 7 words through a 16-word FIFO.
    for (int i = 0; i < 40; i++) add_pkt(7, 1'b0, 1'b0, 0);
    wait_drain("wrap_drain", 4000);
    check_stats("wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
